// File: rtl/fp_scale_pkg.sv
// Shared binary32 field layout, constants and helpers for the power-of-two scaler.
// Build option FP_SCALE_SUBNORM_EN selects gradual underflow instead of flush-to-zero.
package fp_scale_pkg;

  localparam int unsigned FP_W     = 32;
  localparam int unsigned EXP_W    = 8;
  localparam int unsigned MAN_W    = 23;
  localparam int unsigned EXP_BIAS = 127;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

  function automatic logic is_inf_nan(input fp32_t x);
    return x.exp == EXP_MAX;
  endfunction

endpackage

// File: rtl/fp_div_128.sv
// Binary32 divide-by-128: fp_scale_pow2 with SHIFT=7.
module fp_div_128
  import fp_scale_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clk_en,
  input  logic            start,
  input  logic [FP_W-1:0] dataa,
  output logic [FP_W-1:0] result,
  output logic            done
);

  fp_scale_pow2 #(.SHIFT(7)) u_scale (
    .clk     (clk),
    .reset_n (reset_n),
    .clk_en  (clk_en),
    .start   (start),
    .dataa   (dataa),
    .result  (result),
    .done    (done)
  );

endmodule

// File: rtl/fp_half.sv
// Binary32 divide-by-two: fp_scale_pow2 with SHIFT=1.
module fp_half
  import fp_scale_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clk_en,
  input  logic            start,
  input  logic [FP_W-1:0] dataa,
  output logic [FP_W-1:0] result,
  output logic            done
);

  fp_scale_pow2 #(.SHIFT(1)) u_scale (
    .clk     (clk),
    .reset_n (reset_n),
    .clk_en  (clk_en),
    .start   (start),
    .dataa   (dataa),
    .result  (result),
    .done    (done)
  );

endmodule

// File: rtl/fp_rshift_rne.sv
// Right-shifts a 24-bit significand and rounds the kept bits to nearest-even
// using the first dropped bit as guard and the OR of the rest as sticky.
module fp_rshift_rne
  import fp_scale_pkg::*;
(
  input  logic [MAN_W:0] sig,
  input  logic [4:0]     amt,
  output logic [MAN_W:0] rounded
);

  logic [2*MAN_W+1:0] ext;
  logic [MAN_W:0]     kept;
  logic               guard;
  logic               sticky;

  always_comb begin
    ext    = {sig, {(MAN_W+1){1'b0}}} >> amt;
    kept   = ext[2*MAN_W+1:MAN_W+1];
    guard  = ext[MAN_W];
    sticky = |ext[MAN_W-1:0];
    // Shifts of 25+ leave only sticky bits below the guard, so no round-up is possible.
    if (amt >= 5'd25) begin
      rounded = '0;
    end else begin
      rounded = kept + {{MAN_W{1'b0}}, guard & (sticky | kept[0])};
    end
  end

endmodule

// File: rtl/fp_scale_pow2.sv
// Registered binary32 multiply by 2^-SHIFT (1-cycle latency, clk_en gated).
// Build option FP_SCALE_SUBNORM_EN enables gradual underflow; otherwise tiny results flush to signed zero.
module fp_scale_pow2
  import fp_scale_pkg::*;
#(
  parameter int unsigned SHIFT = 7
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clk_en,
  input  logic            start,
  input  logic [FP_W-1:0] dataa,
  output logic [FP_W-1:0] result,
  output logic            done
);

  localparam logic [EXP_W-1:0] SHIFT_E = EXP_W'(SHIFT);

  fp32_t op;
  fp32_t scaled;

  assign op = fp32_t'(dataa);

`ifdef FP_SCALE_SUBNORM_EN
  localparam logic [4:0] SHIFT_A = 5'(SHIFT);

  logic [MAN_W:0] sub_sig;
  logic [MAN_W:0] sub_rnd;
  logic [4:0]     sub_amt;

  always_comb begin
    if (op.exp == '0) begin
      sub_sig = {1'b0, op.man};
      sub_amt = SHIFT_A;
    end else begin
      sub_sig = {1'b1, op.man};
      sub_amt = SHIFT_A - op.exp[4:0] + 5'd1;
    end
  end

  fp_rshift_rne u_rshift (
    .sig     (sub_sig),
    .amt     (sub_amt),
    .rounded (sub_rnd)
  );
`endif

  always_comb begin
    scaled = op;
    if (!is_inf_nan(op)) begin
      if (op.exp > SHIFT_E) begin
        scaled.exp = op.exp - SHIFT_E;
      end else begin
`ifdef FP_SCALE_SUBNORM_EN
        // A rounding carry into bit 23 lands in exp[0], giving the smallest normal.
        scaled = {op.sign, {(EXP_W-1){1'b0}}, sub_rnd};
`else
        scaled = {op.sign, {(FP_W-1){1'b0}}};
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result <= '0;
      done   <= 1'b0;
    end else if (clk_en) begin
      result <= scaled;
      done   <= start;
    end
  end

endmodule

// File: tb/tb_fp_scale_pow2.sv
// Scoreboard bench for fp_scale_pow2 (SHIFT=7) and its SHIFT=1 / SHIFT=7 wrappers,
// with expectations selected by FP_SCALE_SUBNORM_EN.
module tb_fp_scale_pow2;

  typedef struct packed {
    logic        st;
    logic [31:0] e1;
    logic [31:0] e7;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;

  logic [31:0] res7, res1, res128;
  logic        done7, done1, done128;

  int checks = 0;
  int errors = 0;

  exp_t q[$];
  exp_t last_e;
  logic en_edge = 1'b0;

  logic [31:0] vin [0:16] = '{
    32'h41A00000, 32'h43700000, 32'h430C0000, 32'h00000000, 32'h80000000,
    32'h7F800000, 32'h7FC00001, 32'h00800000, 32'h00800003, 32'h00800001,
    32'h80400000, 32'h04000000, 32'h03800000, 32'hBF800000, 32'h00000001,
    32'h00000003, 32'h00FFFFFF};

`ifdef FP_SCALE_SUBNORM_EN
  logic [31:0] ve1 [0:16] = '{
    32'h41200000, 32'h42F00000, 32'h428C0000, 32'h00000000, 32'h80000000,
    32'h7F800000, 32'h7FC00001, 32'h00400000, 32'h00400002, 32'h00400000,
    32'h80200000, 32'h03800000, 32'h03000000, 32'hBF000000, 32'h00000000,
    32'h00000002, 32'h00800000};
  logic [31:0] ve7 [0:16] = '{
    32'h3E200000, 32'h3FF00000, 32'h3F8C0000, 32'h00000000, 32'h80000000,
    32'h7F800000, 32'h7FC00001, 32'h00010000, 32'h00010000, 32'h00010000,
    32'h80008000, 32'h00800000, 32'h00400000, 32'hBC000000, 32'h00000000,
    32'h00000000, 32'h00020000};
`else
  logic [31:0] ve1 [0:16] = '{
    32'h41200000, 32'h42F00000, 32'h428C0000, 32'h00000000, 32'h80000000,
    32'h7F800000, 32'h7FC00001, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h80000000, 32'h03800000, 32'h03000000, 32'hBF000000, 32'h00000000,
    32'h00000000, 32'h00000000};
  logic [31:0] ve7 [0:16] = '{
    32'h3E200000, 32'h3FF00000, 32'h3F8C0000, 32'h00000000, 32'h80000000,
    32'h7F800000, 32'h7FC00001, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h80000000, 32'h00800000, 32'h00000000, 32'hBC000000, 32'h00000000,
    32'h00000000, 32'h00000000};
`endif

  always #5 clk = ~clk;

  fp_scale_pow2 #(.SHIFT(7)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clk_en  (clk_en),
    .start   (start),
    .dataa   (dataa),
    .result  (res7),
    .done    (done7)
  );

  fp_half u_half (
    .clk     (clk),
    .reset_n (reset_n),
    .clk_en  (clk_en),
    .start   (start),
    .dataa   (dataa),
    .result  (res1),
    .done    (done1)
  );

  fp_div_128 u_div128 (
    .clk     (clk),
    .reset_n (reset_n),
    .clk_en  (clk_en),
    .start   (start),
    .dataa   (dataa),
    .result  (res128),
    .done    (done128)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %08h, expected %08h", name, $time, act, req);
    end
  endtask

  // One clock cycle of stimulus; enabled edges out of reset enqueue their expectation.
  task automatic cyc(input logic st, input logic en, input int v);
    start  = st;
    clk_en = en;
    dataa  = vin[v];
    @(posedge clk);
    if (en && reset_n) q.push_back('{st: st, e1: ve1[v], e7: ve7[v]});
    #1;
  endtask

  always @(posedge clk) en_edge <= clk_en && reset_n;

  // Monitor: enabled edges consume the next expectation; disabled edges must hold the last one.
  always @(negedge clk) begin
    if (reset_n) begin
      if (en_edge) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_underrun at %0t: got empty queue, expected an entry", $time);
        end else begin
          last_e = q.pop_front();
        end
      end
      chk("result_shift7",   res7,   last_e.e7);
      chk("result_half",     res1,   last_e.e1);
      chk("result_div128",   res128, last_e.e7);
      chk("done_shift7",     {31'd0, done7},   {31'd0, last_e.st});
      chk("done_half",       {31'd0, done1},   {31'd0, last_e.st});
      chk("done_div128",     {31'd0, done128}, {31'd0, last_e.st});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    last_e  = '0;
    reset_n = 1'b0;
    start   = 1'b0;
    clk_en  = 1'b0;
    dataa   = '0;
    #1;
    chk("reset_result", res7, 32'h0);
    chk("reset_done",   {31'd0, done7}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 reset_n = 1'b1;

    // Every vector back-to-back with start held.
    for (int v = 0; v < 17; v++) cyc(1'b1, 1'b1, v);

    // Start on cycles 0, 1, 3.
    cyc(1'b1, 1'b1, 0);
    cyc(1'b1, 1'b1, 1);
    cyc(1'b0, 1'b1, 2);
    cyc(1'b1, 1'b1, 3);
    cyc(1'b0, 1'b1, 4);

    // clk_en low for two cycles while inputs change.
    cyc(1'b1, 1'b1, 5);
    cyc(1'b1, 1'b0, 6);
    cyc(1'b0, 1'b0, 7);
    cyc(1'b0, 1'b1, 8);
    cyc(1'b1, 1'b1, 16);

    // Asynchronous reset between edges.
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midreset_result_shift7", res7, 32'h0);
    chk("midreset_result_half",   res1, 32'h0);
    chk("midreset_done_shift7",   {31'd0, done7}, 32'h0);
    chk("midreset_done_half",     {31'd0, done1}, 32'h0);
    last_e = '0;
    cyc(1'b1, 1'b1, 9);
    @(negedge clk);
    #1 reset_n = 1'b1;
    cyc(1'b1, 1'b1, 2);
    cyc(1'b0, 1'b1, 13);
    cyc(1'b0, 1'b0, 0);

    repeat (2) @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
